// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared FSM encoding and AXI response codes for the imem read arbiter
package imem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // On a tie the master that was not served last wins; otherwise the lone requester.
  always_comb begin
    gnt_valid = |req;
    if (&req) gnt_idx = ~last_gnt;
    else      gnt_idx = req[1];
  end

endmodule

// File: rtl/imem_rd_arbiter.sv
// rtl/imem_rd_arbiter.sv - two-master AXI4-Lite read arbiter in front of imem_axi_lite
// One transaction in flight; out-of-range and stalled reads complete locally with SLVERR.
module imem_rd_arbiter
  import imem_arb_pkg::*;
#(
  parameter int                    MEM_SIZE       = 16384,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] PROGADDR_RESET = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_s0_axi_araddr,
  input  logic                  i_s0_axi_arvalid,
  output logic                  o_s0_axi_arready,
  output logic [DATA_WIDTH-1:0] o_s0_axi_rdata,
  output logic [1:0]            o_s0_axi_rresp,
  output logic                  o_s0_axi_rvalid,
  input  logic                  i_s0_axi_rready,
  input  logic [ADDR_WIDTH-1:0] i_s1_axi_araddr,
  input  logic                  i_s1_axi_arvalid,
  output logic                  o_s1_axi_arready,
  output logic [DATA_WIDTH-1:0] o_s1_axi_rdata,
  output logic [1:0]            o_s1_axi_rresp,
  output logic                  o_s1_axi_rvalid,
  input  logic                  i_s1_axi_rready,
  output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic                  o_m_axi_arvalid,
  input  logic                  i_m_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic                  i_m_axi_rvalid,
  output logic                  o_m_axi_rready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Window bounds carry one extra bit so the end address cannot wrap to zero.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, PROGADDR_RESET};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH + 1)'(MEM_SIZE);

  arb_state_t            r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic                  r_gnt, w_gnt_next;
  logic                  r_last_gnt, w_last_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_next;
  logic [1:0]            r_rresp, w_rresp_next;

  logic                  w_gnt_valid, w_gnt_idx;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic                  w_in_range, w_s_rready;

  logic                  w_s0_arready, w_s1_arready, w_s0_rvalid, w_s1_rvalid;
  logic [DATA_WIDTH-1:0] w_s0_rdata, w_s1_rdata;
  logic [1:0]            w_s0_rresp, w_s1_rresp;
  logic                  w_m_arvalid, w_m_rready;
  logic [ADDR_WIDTH-1:0] w_m_araddr;

  rr_arb2 u_rr_arb2 (
    .req       ({i_s1_axi_arvalid, i_s0_axi_arvalid}),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_req_addr = w_gnt_idx ? i_s1_axi_araddr : i_s0_axi_araddr;
  assign w_in_range = ({1'b0, w_req_addr} >= WIN_LO) && ({1'b0, w_req_addr} < WIN_HI);
  assign w_s_rready = r_gnt ? i_s1_axi_rready : i_s0_axi_rready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_gnt_next   = r_gnt;
    w_last_next  = r_last_gnt;
    w_cnt_next   = r_cnt;
    w_rdata_next = r_rdata;
    w_rresp_next = r_rresp;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_gnt_next  = w_gnt_idx;
          w_addr_next = w_req_addr;
          if (w_in_range) begin
            w_state_next = ST_ADDR;
          end else begin
            w_rdata_next = '0;
            w_rresp_next = RRESP_SLVERR;
            w_state_next = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (i_m_axi_arready) begin
          w_cnt_next   = '0;
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        // Real data wins over a timeout landing on the same cycle.
        if (i_m_axi_rvalid) begin
          w_rdata_next = i_m_axi_rdata;
          w_rresp_next = RRESP_OKAY;
          w_state_next = ST_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_rdata_next = '0;
          w_rresp_next = RRESP_SLVERR;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_s_rready) begin
          w_last_next  = r_gnt;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state so every port is a flop.
  always_comb begin
    w_s0_arready = (r_state == ST_IDLE) && w_gnt_valid && !w_gnt_idx;
    w_s1_arready = (r_state == ST_IDLE) && w_gnt_valid && w_gnt_idx;
    w_s0_rvalid  = (w_state_next == ST_RESP) && !w_gnt_next;
    w_s1_rvalid  = (w_state_next == ST_RESP) && w_gnt_next;
    w_s0_rdata   = w_s0_rvalid ? w_rdata_next : '0;
    w_s1_rdata   = w_s1_rvalid ? w_rdata_next : '0;
    w_s0_rresp   = w_s0_rvalid ? w_rresp_next : RRESP_OKAY;
    w_s1_rresp   = w_s1_rvalid ? w_rresp_next : RRESP_OKAY;
    w_m_arvalid  = (w_state_next == ST_ADDR);
    w_m_araddr   = w_m_arvalid ? w_addr_next : '0;
    w_m_rready   = (w_state_next == ST_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr           <= '0;
      r_gnt            <= 1'b0;
      r_last_gnt       <= 1'b1;
      r_cnt            <= '0;
      r_rdata          <= '0;
      r_rresp          <= RRESP_OKAY;
      o_s0_axi_arready <= 1'b0;
      o_s1_axi_arready <= 1'b0;
      o_s0_axi_rvalid  <= 1'b0;
      o_s1_axi_rvalid  <= 1'b0;
      o_s0_axi_rdata   <= '0;
      o_s1_axi_rdata   <= '0;
      o_s0_axi_rresp   <= RRESP_OKAY;
      o_s1_axi_rresp   <= RRESP_OKAY;
      o_m_axi_arvalid  <= 1'b0;
      o_m_axi_araddr   <= '0;
      o_m_axi_rready   <= 1'b0;
    end else begin
      r_addr           <= w_addr_next;
      r_gnt            <= w_gnt_next;
      r_last_gnt       <= w_last_next;
      r_cnt            <= w_cnt_next;
      r_rdata          <= w_rdata_next;
      r_rresp          <= w_rresp_next;
      o_s0_axi_arready <= w_s0_arready;
      o_s1_axi_arready <= w_s1_arready;
      o_s0_axi_rvalid  <= w_s0_rvalid;
      o_s1_axi_rvalid  <= w_s1_rvalid;
      o_s0_axi_rdata   <= w_s0_rdata;
      o_s1_axi_rdata   <= w_s1_rdata;
      o_s0_axi_rresp   <= w_s0_rresp;
      o_s1_axi_rresp   <= w_s1_rresp;
      o_m_axi_arvalid  <= w_m_arvalid;
      o_m_axi_araddr   <= w_m_araddr;
      o_m_axi_rready   <= w_m_rready;
    end
  end

endmodule

// File: tb/tb_imem_rd_arbiter.sv
// tb/tb_imem_rd_arbiter.sv - directed and random bench for imem_rd_arbiter with a memory slave model
module tb_imem_rd_arbiter;

  localparam int TO   = 255;
  localparam int SIZE = 16384;
  localparam longint BASE = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s0_araddr = '0, s1_araddr = '0;
  logic        s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic        s0_rready = 1'b0, s1_rready = 1'b0;
  logic        o_s0_axi_arready, o_s1_axi_arready, o_s0_axi_rvalid, o_s1_axi_rvalid;
  logic [31:0] o_s0_axi_rdata, o_s1_axi_rdata;
  logic [1:0]  o_s0_axi_rresp, o_s1_axi_rresp;
  logic [31:0] o_m_axi_araddr;
  logic        o_m_axi_arvalid, o_m_axi_rready;

  logic        sl_arready, sl_rvalid;
  logic [31:0] sl_rdata;
  logic [31:0] mem [0:4095];
  bit          stub_mode = 1'b0;

  imem_rd_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .i_s0_axi_araddr  (s0_araddr),
    .i_s0_axi_arvalid (s0_arvalid),
    .o_s0_axi_arready (o_s0_axi_arready),
    .o_s0_axi_rdata   (o_s0_axi_rdata),
    .o_s0_axi_rresp   (o_s0_axi_rresp),
    .o_s0_axi_rvalid  (o_s0_axi_rvalid),
    .i_s0_axi_rready  (s0_rready),
    .i_s1_axi_araddr  (s1_araddr),
    .i_s1_axi_arvalid (s1_arvalid),
    .o_s1_axi_arready (o_s1_axi_arready),
    .o_s1_axi_rdata   (o_s1_axi_rdata),
    .o_s1_axi_rresp   (o_s1_axi_rresp),
    .o_s1_axi_rvalid  (o_s1_axi_rvalid),
    .i_s1_axi_rready  (s1_rready),
    .o_m_axi_araddr   (o_m_axi_araddr),
    .o_m_axi_arvalid  (o_m_axi_arvalid),
    .i_m_axi_arready  (sl_arready),
    .i_m_axi_rdata    (sl_rdata),
    .i_m_axi_rvalid   (sl_rvalid),
    .o_m_axi_rready   (o_m_axi_rready)
  );

  // imem_axi_lite behaviour: registered arready, one-cycle rvalid pulse after the handshake.
  always @(posedge clk) begin
    if (reset) begin
      sl_arready <= 1'b0;
      sl_rvalid  <= 1'b0;
      sl_rdata   <= '0;
    end else begin
      sl_rvalid  <= 1'b0;
      sl_arready <= o_m_axi_arvalid && !sl_arready;
      if (o_m_axi_arvalid && sl_arready && !stub_mode) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= mem[o_m_axi_araddr[13:2]];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int m_arvalid_cycles = 0;
  int mdl_last = 1;

  always @(negedge clk) if (o_m_axi_arvalid) m_arvalid_cycles++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= BASE) && (la < BASE + SIZE);
  endfunction

  // Expected {rresp, rdata} for a read of address a.
  function automatic logic [33:0] model(input logic [31:0] a);
    if (!in_window(a)) return {2'b10, 32'h0};
    if (stub_mode)     return {2'b10, 32'h0};
    return {2'b00, mem[int'((longint'(a) - BASE) / 4)]};
  endfunction

  function automatic logic rv(input int i);
    return (i != 0) ? o_s1_axi_rvalid : o_s0_axi_rvalid;
  endfunction

  function automatic logic [33:0] rsp(input int i);
    return (i != 0) ? {o_s1_axi_rresp, o_s1_axi_rdata} : {o_s0_axi_rresp, o_s0_axi_rdata};
  endfunction

  function automatic logic any_out();
    return |{o_s0_axi_arready, o_s0_axi_rdata, o_s0_axi_rresp, o_s0_axi_rvalid,
             o_s1_axi_arready, o_s1_axi_rdata, o_s1_axi_rresp, o_s1_axi_rvalid,
             o_m_axi_arvalid, o_m_axi_araddr, o_m_axi_rready};
  endfunction

  task automatic set_rready(input int i, input logic v);
    if (i != 0) s1_rready = v; else s0_rready = v;
  endtask

  // Present requests, then serve them one at a time, checking grant order, latency and data.
  task automatic run_round(input bit q0, input bit q1, input logic [31:0] a0,
                           input logic [31:0] a1, input int hold);
    bit pend [2];
    logic [31:0] addr [2];
    int got, exp_w, w, n, base_m, exp_lat;
    bit ok, inr;
    logic [33:0] e;
    pend[0] = q0; pend[1] = q1; addr[0] = a0; addr[1] = a1;
    s0_araddr = a0; s0_arvalid = q0;
    s1_araddr = a1; s1_arvalid = q1;
    while (pend[0] || pend[1]) begin
      exp_w  = (pend[0] && pend[1]) ? ((mdl_last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
      base_m = m_arvalid_cycles;
      ok = 1'b0;
      w  = 0;
      while (!ok && w < 20) begin
        @(negedge clk);
        w++;
        ok = o_s0_axi_arready | o_s1_axi_arready;
      end
      chk("arready_latency", w, 1);
      if (!ok) begin
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        return;
      end
      got = o_s1_axi_arready ? 1 : 0;
      chk("grant_idx", got, exp_w);
      chk("arready_onehot", o_s0_axi_arready & o_s1_axi_arready, 1'b0);
      if (got != 0) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
      pend[got] = 1'b0;
      inr = in_window(addr[got]);
      e   = model(addr[got]);
      exp_lat = !inr ? 0 : (stub_mode ? 2 + TO : 3);
      if (inr) chk("m_araddr", {o_m_axi_arvalid, o_m_axi_araddr}, {1'b1, addr[got]});
      n = 0;
      while (!rv(got) && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("rvalid_latency", n, exp_lat);
      if (!rv(got)) begin
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        return;
      end
      chk("resp_data", rsp(got), e);
      chk("other_quiet", {rv(1 - got), rsp(1 - got)}, 35'h0);
      if (!inr) chk("oor_no_m_arvalid", m_arvalid_cycles - base_m, 0);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_stable", {rv(got), rsp(got)}, {1'b1, e});
        chk("hold_no_arready", o_s0_axi_arready | o_s1_axi_arready, 1'b0);
      end
      set_rready(got, 1'b1);
      @(negedge clk);
      chk("rvalid_drop", rv(got), 1'b0);
      set_rready(got, 1'b0);
      mdl_last = got;
    end
  endtask

  initial begin
    bit q0, q1, ok;
    logic [31:0] a0, a1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[4] = 32'h0000_0013;

    repeat (3) @(negedge clk);
    chk("reset_outputs", any_out(), 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", any_out(), 1'b0);

    // Tie from reset, single fetch, then alternating ties
    run_round(1, 1, 32'h20, 32'h24, 0);
    run_round(1, 0, 32'h10, 32'h0, 0);
    run_round(1, 1, 32'h30, 32'h34, 0);
    run_round(1, 1, 32'h3FFC, 32'h0, 0);

    // Backpressure with the other master waiting
    run_round(1, 1, 32'h44, 32'h48, 10);

    // Window boundary and out-of-range requests
    run_round(1, 0, 32'h4000, 32'h0, 0);
    run_round(0, 1, 32'h0, 32'hFFFF_FFFC, 2);
    run_round(1, 1, 32'h4004, 32'h3FF8, 1);

    for (int r = 0; r < 40; r++) begin
      q0 = $urandom_range(0, 1);
      q1 = $urandom_range(0, 1);
      if (!q0 && !q1) q0 = 1'b1;
      a0 = ($urandom_range(0, 3) == 0) ? 32'h4000 + 32'($urandom_range(0, 4000)) * 4
                                       : 32'($urandom_range(0, 4095)) * 4;
      a1 = ($urandom_range(0, 3) == 0) ? 32'h4000 + 32'($urandom_range(0, 4000)) * 4
                                       : 32'($urandom_range(0, 4095)) * 4;
      run_round(q0, q1, a0, a1, $urandom_range(0, 3));
    end

    // Slave never answers: forced SLVERR
    stub_mode = 1'b1;
    run_round(1, 0, 32'h100, 32'h0, 0);
    run_round(0, 1, 32'h0, 32'h104, 1);

    // Reset while in DATA, then a fresh tie
    s0_araddr  = 32'h40;
    s0_arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = o_s0_axi_arready;
    end
    chk("abort_arready", ok, 1'b1);
    s0_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_data", o_m_axi_rready, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", any_out(), 1'b0);
    reset     = 1'b0;
    stub_mode = 1'b0;
    mdl_last  = 1;
    run_round(1, 1, 32'h10, 32'h14, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_rd_arbiter.md
# imem_rd_arbiter

Two-master AXI4-Lite read-channel arbiter that shares the single read port of `imem_axi_lite` between the CPU instruction-fetch port (master 0) and the debug/boot-loader read port (master 1). It issues one outstanding transaction at a time and grants round-robin. It buffers the slave's one-cycle read-data pulse until the owning master accepts it. It also locally rejects out-of-range addresses and stalled transactions with SLVERR.

## Interface
- `MEM_SIZE`, 16384: bytes of instruction memory behind the slave port.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `PROGADDR_RESET`, 32'h0000_0000: base address of the memory window.
- `TIMEOUT_CYCLES`, 255: maximum cycles in DATA before a forced SLVERR; must be at least 4.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `i_sN_axi_araddr`  in  ADDR_WIDTH  master N read address (N = 0, 1).
- `i_sN_axi_arvalid`  in  1  master N address valid.
- `o_sN_axi_arready`  out  1  master N address accepted (one-cycle pulse).
- `o_sN_axi_rdata`  out  DATA_WIDTH  master N read data.
- `o_sN_axi_rresp`  out  2  2'b00 OKAY, 2'b10 SLVERR.
- `o_sN_axi_rvalid`  out  1  master N read data valid.
- `i_sN_axi_rready`  in  1  master N ready for data.
- `o_m_axi_araddr`  out  ADDR_WIDTH  address toward `imem_axi_lite`.
- `o_m_axi_arvalid`  out  1  address valid toward the slave.
- `i_m_axi_arready`  in  1  slave address ready.
- `i_m_axi_rdata`  in  DATA_WIDTH  slave data.
- `i_m_axi_rvalid`  in  1  slave data valid; may be a single-cycle pulse.
- `o_m_axi_rready`  out  1  ready toward the slave.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - Arbitrate the `arvalid` inputs.
  - Latch the winner's address into `addr_q` and the winner's index into `gnt_q`.
  - Pulse that master's `arready` high for the next cycle.
  - In-range address, i.e. `PROGADDR_RESET <= addr < PROGADDR_RESET + MEM_SIZE`: go to ADDR.
  - Out-of-range address: load `rdata_q = 0` and `rresp_q = SLVERR`, then go to RESP.
- **ADDR**
  - Drive `o_m_axi_arvalid = 1` and `o_m_axi_araddr = addr_q`.
  - On a cycle where `arvalid && arready`: drop `arvalid`, clear the timeout counter, go to DATA.
- **DATA**
  - Drive `o_m_axi_rready = 1`.
  - On `i_m_axi_rvalid`: capture `rdata_q` with `rresp_q = OKAY`, go to RESP.
  - The counter increments every DATA cycle. When it reaches `TIMEOUT_CYCLES`: load `rdata_q = 0` and `rresp_q = SLVERR`, go to RESP.
  - A late slave `rvalid` arriving after a timeout is ignored, because `rready` is low outside DATA.
- **RESP**
  - Assert the granted master's `rvalid` with `rdata_q` and `rresp_q`. Hold these stable until that master's `rready`.
  - On handshake: update `last_gnt = gnt_q`, go to IDLE.
- **Round-robin**
  - A single requester always wins.
  - With both requesting, the master that is not `last_gnt` wins.
  - After reset, `last_gnt = 1`, so master 0 wins the first tie.
- The non-granted master sees `arready = 0`, `rvalid = 0` and `rdata = 0` throughout.
- Only one transaction is in flight. New requests are sampled only in IDLE.
- Address arithmetic uses ADDR_WIDTH+1 bits for the upper bound, so the window end does not wrap.

## Timing
- **Reset values:** all `arready` = 0, all `rvalid` = 0, all `rdata` = 0, all `rresp` = 0, `o_m_axi_arvalid` = 0, `o_m_axi_araddr` = 0, `o_m_axi_rready` = 0. State is IDLE, `last_gnt = 1`, counter = 0.
- Reset asserted mid-transaction aborts it immediately. The slave shares the system reset, so no cleanup handshake is issued.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Cycle-level latency, with `arvalid` seen in cycle N:**
  - `s_arready` and `m_arvalid` are high in cycle N+1.
  - Against `imem_axi_lite`, `m_arready` is seen in N+2 and `m_rvalid` in N+3.
  - `s_rvalid` is high from N+4.
  - If `rready` is held high, the next request is accepted in cycle N+5.
- Out-of-range request: `s_rvalid` with SLVERR is high in cycle N+1, together with `arready`.
- Masters must hold `arvalid` and `araddr` until `arready`, per AXI. A master that drops `arvalid` while waiting loses arbitration without error.

## Structure
- **Shared package `imem_arb_pkg`:**
  - State encoding: IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3.
  - `RRESP_OKAY` = 2'b00 and `RRESP_SLVERR` = 2'b10.
- **Sub-module `rr_arb2`:**
  - Combinational two-way round-robin pick.
  - Inputs: `req[1:0]`, `last_gnt`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - Instantiated once. The FSM and registers stay in the top module.

## Test plan
- **Single fetch:** m0 reads 0x0000_0010 with memory word 4 = 0x0000_0013 → m0 `rvalid` in cycle N+4, `rdata` = 0x0000_0013, `rresp` = 00; m1 outputs stay 0.
- **Tie:** both masters request from reset → m0 served first. With both re-requesting, the order is m1, then m0, then m1.
- **Backpressure:** m1 holds `rready` = 0 for 10 cycles → `rvalid` and `rdata` are held stable, and m0's `arvalid` is not acknowledged until the m1 handshake completes.
- **Out of range:** m0 reads 0x0000_4000 (MEM_SIZE 16384) → SLVERR with `rdata` = 0 in cycle N+1, and `o_m_axi_arvalid` is never asserted.
- **Timeout and reset:**
  - Stub slave never raises `rvalid` → SLVERR after exactly `TIMEOUT_CYCLES` DATA cycles.
  - Assert `reset` during DATA in a separate run → all outputs 0 on the next cycle, and a fresh request then completes normally.
